// File: rtl/dsm2_echip65.sv
// Second-order single-bit delta-sigma modulator with a one-deep sample holding register.
// One input sample is consumed per OSR modulator clocks; flags report saturation and underrun.
module dsm2_echip65 #(
  parameter int OSR        = 256,
  parameter int CNT_WIDTH  = $clog2(OSR),
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  enable,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  bit_out,
  output logic                  sample_strobe,
  input  logic                  clr_flags,
  output logic                  sat_flag,
  output logic                  underrun_flag
);

  // Two guard bits: acc2 + acc1' + FS can exceed the range of a single guard bit.
  localparam int SUM_WIDTH = ACC_WIDTH + 2;
  localparam logic signed [SUM_WIDTH-1:0] ACC_MAX = {3'b000, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [SUM_WIDTH-1:0] ACC_MIN = -ACC_MAX;
  localparam logic signed [ACC_WIDTH-1:0] FS =
    {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, 1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(OSR - 1);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_e;

  function automatic logic signed [ACC_WIDTH-1:0] sat_f(input logic signed [SUM_WIDTH-1:0] s);
    logic signed [ACC_WIDTH-1:0] r;
    if (s > ACC_MAX) begin
      r = ACC_MAX[ACC_WIDTH-1:0];
    end else if (s < ACC_MIN) begin
      r = ACC_MIN[ACC_WIDTH-1:0];
    end else begin
      r = s[ACC_WIDTH-1:0];
    end
    return r;
  endfunction

  function automatic logic clamp_f(input logic signed [SUM_WIDTH-1:0] s);
    return (s > ACC_MAX) || (s < ACC_MIN);
  endfunction

  function automatic logic signed [SUM_WIDTH-1:0] ext_f(input logic signed [ACC_WIDTH-1:0] v);
    return {{2{v[ACC_WIDTH-1]}}, v};
  endfunction

  state_e                         state_q, state_d;
  logic [CNT_WIDTH-1:0]           cnt_q, cnt_d;
  logic signed [ACC_WIDTH-1:0]    acc1_q, acc1_d, acc2_q, acc2_d;
  logic [DATA_WIDTH-1:0]          hold_q, hold_d, active_q, active_d;
  logic                           hold_full_q, hold_full_d;
  logic                           bit_out_q, bit_out_d;
  logic                           strobe_q, strobe_d;
  logic                           sat_q, sat_d, unr_q, unr_d;

  logic                           take_s, start_s, boundary_s, sat_set_s, unr_set_s;
  logic signed [SUM_WIDTH-1:0]    x_s, fb_s, sum1_s, sum2_s;
  logic signed [ACC_WIDTH-1:0]    acc1_new_s, acc2_new_s;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = (enable && hold_full_q) ? RUN : IDLE;
      RUN:     state_d = enable ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Loop arithmetic and control events
  always_comb begin
    take_s     = in_valid && !hold_full_q;
    start_s    = (state_q == IDLE) && enable && hold_full_q;
    boundary_s = (state_q == RUN) && enable && (cnt_q == CNT_LAST);
    x_s        = {{(SUM_WIDTH-DATA_WIDTH){active_q[DATA_WIDTH-1]}}, active_q};
    fb_s       = bit_out_q ? ext_f(FS) : -ext_f(FS);
    sum1_s     = ext_f(acc1_q) + x_s - fb_s;
    acc1_new_s = sat_f(sum1_s);
    sum2_s     = ext_f(acc2_q) + ext_f(acc1_new_s) - fb_s;
    acc2_new_s = sat_f(sum2_s);
  end

  // Datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    acc1_d      = acc1_q;
    acc2_d      = acc2_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    active_d    = active_q;
    bit_out_d   = bit_out_q;
    strobe_d    = 1'b0;
    sat_set_s   = 1'b0;
    unr_set_s   = 1'b0;
    if (take_s) begin
      hold_d      = in_data;
      hold_full_d = 1'b1;
    end else begin
      hold_d      = hold_q;
    end
    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        acc1_d    = '0;
        acc2_d    = '0;
        bit_out_d = 1'b0;
        strobe_d  = start_s;
        if (start_s) begin
          active_d    = hold_q;
          hold_full_d = 1'b0;
        end else begin
          active_d    = active_q;
        end
      end
      RUN: begin
        if (enable) begin
          cnt_d     = boundary_s ? '0 : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
          acc1_d    = acc1_new_s;
          acc2_d    = acc2_new_s;
          bit_out_d = !acc2_new_s[ACC_WIDTH-1];
          strobe_d  = boundary_s;
          sat_set_s = clamp_f(sum1_s) || clamp_f(sum2_s);
          // Boundary with nothing held reuses the current active sample.
          if (boundary_s && hold_full_q) begin
            active_d    = hold_q;
            hold_full_d = 1'b0;
          end else if (boundary_s) begin
            unr_set_s   = 1'b1;
          end else begin
            active_d    = active_q;
          end
        end else begin
          cnt_d     = '0;
          acc1_d    = '0;
          acc2_d    = '0;
          bit_out_d = 1'b0;
        end
      end
      default: begin
        cnt_d     = '0;
        acc1_d    = '0;
        acc2_d    = '0;
        bit_out_d = 1'b0;
      end
    endcase
    sat_d = sat_set_s ? 1'b1 : (clr_flags ? 1'b0 : sat_q);
    unr_d = unr_set_s ? 1'b1 : (clr_flags ? 1'b0 : unr_q);
  end

  // Datapath registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      acc1_q      <= '0;
      acc2_q      <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      active_q    <= '0;
      bit_out_q   <= 1'b0;
      strobe_q    <= 1'b0;
      sat_q       <= 1'b0;
      unr_q       <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc1_q      <= acc1_d;
      acc2_q      <= acc2_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      active_q    <= active_d;
      bit_out_q   <= bit_out_d;
      strobe_q    <= strobe_d;
      sat_q       <= sat_d;
      unr_q       <= unr_d;
    end
  end

  // Outputs
  always_comb begin
    in_ready      = !hold_full_q;
    bit_out       = bit_out_q;
    sample_strobe = strobe_q;
    sat_flag      = sat_q;
    underrun_flag = unr_q;
  end

endmodule

// File: tb/tb_dsm2_echip65.sv
// Directed bench for dsm2_echip65: reset, framing, handshake, density, underrun,
// saturation and enable-drop behaviour with hand-computed expectations.
module tb_dsm2_echip65;

  logic        clk = 1'b0;
  logic        reset_n, enable, in_valid, clr_flags;
  logic [15:0] in_data;
  logic        in_ready, bit_out, sample_strobe, sat_flag, underrun_flag;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  dsm2_echip65 dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready), .bit_out(bit_out),
    .sample_strobe(sample_strobe), .clr_flags(clr_flags),
    .sat_flag(sat_flag), .underrun_flag(underrun_flag)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint got, input longint exp, input longint tol = 0);
    total++;
    if (got < exp - tol || got > exp + tol) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d tol=%0d", tag, got, exp, tol);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0; enable = 1'b0; in_valid = 1'b0; clr_flags = 1'b0; in_data = 16'h0000;
    tick(); tick();
    reset_n = 1'b1;
    tick();
  endtask

  // Push one word from IDLE, then raise enable; returns just after the start edge.
  task automatic start_with(input logic [15:0] w);
    in_data = w; in_valid = 1'b1;
    tick();
    in_valid = 1'b0; enable = 1'b1;
    tick();
  endtask

  task automatic wait_strobe(output int n, output logic rdy_seen, output logic unr_pre);
    n = 0; rdy_seen = 1'b0; unr_pre = 1'b0;
    do begin
      tick();
      n++;
      if (!sample_strobe) begin
        rdy_seen = rdy_seen | in_ready;
        unr_pre  = underrun_flag;
      end
    end while (!sample_strobe && n < 300);
  endtask

  task automatic count_ones(input int len, output int ones);
    ones = 0;
    repeat (len) begin
      tick();
      ones += int'(bit_out);
    end
  endtask

  int          n, ones;
  logic        rdy_seen, unr_pre, strobe_seen;
  longint      a1, a2, mx1, mn1, mx2;

  initial begin
    do_reset();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_bit_out", bit_out, 0);
    chk("rst_strobe", sample_strobe, 0);
    chk("rst_sat", sat_flag, 0);
    chk("rst_unr", underrun_flag, 0);

    // Start, framing and underrun with x = 0
    start_with(16'h0000);
    chk("strobe_start", sample_strobe, 1);
    tick();
    chk("strobe_one_cycle", sample_strobe, 0);
    wait_strobe(n, rdy_seen, unr_pre);
    chk("frame_len", n, 255);
    chk("unr_before_boundary", unr_pre, 0);
    chk("unr_set", underrun_flag, 1);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("unr_clr", underrun_flag, 0);
    wait_strobe(n, rdy_seen, unr_pre);
    chk("frame_len2", n, 255);
    chk("unr_clr_held", unr_pre, 0);
    chk("unr_set2", underrun_flag, 1);
    repeat (512) tick();
    count_ones(256, ones);
    chk("dens_zero", ones, 128, 2);

    do_reset();
    start_with(16'h4000);
    repeat (1024) tick();
    count_ones(256, ones);
    chk("dens_pos_half", ones, 192, 2);

    do_reset();
    start_with(16'hC000);
    repeat (1024) tick();
    count_ones(256, ones);
    chk("dens_neg_half", ones, 64, 2);

    // Backpressure: A then B with in_valid held
    do_reset();
    enable = 1'b1; in_valid = 1'b1; in_data = 16'h1111;
    tick();
    chk("hs_a_accepted", in_ready, 0);
    chk("hs_no_strobe", sample_strobe, 0);
    in_data = 16'h2222;
    tick();
    chk("hs_start_strobe", sample_strobe, 1);
    chk("hs_ready_after_start", in_ready, 1);
    chk("hs_active_a", dut.active_q, 16'h1111);
    tick();
    chk("hs_b_accepted", in_ready, 0);
    in_valid = 1'b0;
    wait_strobe(n, rdy_seen, unr_pre);
    chk("hs_frame_len", n, 255);
    chk("hs_ready_low_in_frame", rdy_seen, 0);
    chk("hs_active_b", dut.active_q, 16'h2222);
    chk("hs_ready_after_bnd", in_ready, 1);
    chk("hs_no_underrun", underrun_flag, 0);

    // Enable drop mid-frame keeps the held word
    in_data = 16'h3333; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("ed_held", in_ready, 0);
    repeat (10) tick();
    enable = 1'b0;
    tick();
    chk("ed_bit_out", bit_out, 0);
    chk("ed_acc1", dut.acc1_q, 0);
    chk("ed_acc2", dut.acc2_q, 0);
    chk("ed_strobe", sample_strobe, 0);
    chk("ed_hold_kept", in_ready, 0);
    tick();
    enable = 1'b1;
    tick();
    chk("ed_restart_strobe", sample_strobe, 1);
    chk("ed_active_c", dut.active_q, 16'h3333);

    // Saturation with near full-scale input
    do_reset();
    start_with(16'h7FFF);
    mx1 = -(64'sd1 <<< 40); mn1 = 64'sd1 <<< 40; mx2 = mx1;
    for (int i = 0; i < 4096; i++) begin
      clr_flags = (i == 100);
      tick();
      a1 = longint'(dut.acc1_q);
      a2 = longint'(dut.acc2_q);
      if (a1 > mx1) mx1 = a1;
      if (a1 < mn1) mn1 = a1;
      if (a2 > mx2) mx2 = a2;
      if (i == 100) chk("sat_clr_same_edge", sat_flag, 1);
    end
    clr_flags = 1'b0;
    chk("sat_flag", sat_flag, 1);
    chk("sat_acc2_peak", mx2, 524287);
    chk("sat_acc1_range", (mx1 <= 524287 && mn1 >= -524287), 1);
    chk("sat_bit_out", bit_out, 1);
    chk("sat_unr_pre_rst", underrun_flag, 1);

    // Asynchronous reset mid-cycle while running
    #2 reset_n = 1'b0;
    #1;
    chk("arst_bit_out", bit_out, 0);
    chk("arst_sat", sat_flag, 0);
    chk("arst_unr", underrun_flag, 0);
    chk("arst_strobe", sample_strobe, 0);
    chk("arst_in_ready", in_ready, 1);
    #1 reset_n = 1'b1;
    strobe_seen = 1'b0;
    repeat (20) begin
      tick();
      strobe_seen = strobe_seen | sample_strobe;
    end
    chk("arst_no_restart", strobe_seen, 0);
    chk("arst_idle_bit_out", bit_out, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
